freq_gen_module: RTL and testbench

//  Programmable square-wave generator (phase-accumulator NCO) producing a signal of a requested

---
 rtl/freq_gen_module.sv | 126 ++++++++++++
 tb/tb_freq_gen_module.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gen_module.sv
// freq_gen_module - phase-accumulator NCO square-wave generator with Hz-to-increment divider
// A new frequency is converted by a 32-step restoring divider and swapped in on a period boundary.
module freq_gen_module #(
   parameter logic [31:0] freq_base = 32'd200_000_000,
   parameter int          ACC_W     = 32
) (
   input  logic             clk_base,
   input  logic             aclr,
   input  logic [31:0]      freq_set,
   input  logic             set_valid,
   output logic             set_ready,
   output logic             set_err,
   output logic             clk_out,
   output logic             tick,
   output logic [ACC_W-1:0] inc_cur,
   output logic             busy
);

   localparam logic [31:0] FREQ_MAX = freq_base / 32'd2;
   localparam logic [32:0] DIVISOR  = {1'b0, freq_base};

   typedef enum logic [1:0] {IDLE, DIV, APPLY} state_t;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc_pend;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic [31:0]      rem;
   logic [31:0]      quot;
   logic [4:0]       cnt;
   logic [32:0]      rem_sh;
   logic [32:0]      rem_diff;
   logic [31:0]      rem_nxt;
   logic             q_bit;
   logic             clamped;
   logic [31:0]      f_req;
   logic             accept;
   logic             apply_now;

   assign sum   = {1'b0, acc} + {1'b0, inc_cur};
   assign carry = sum[ACC_W];

   assign clamped = freq_set > FREQ_MAX;
   assign f_req   = clamped ? FREQ_MAX : freq_set;

   // One restoring step; rem stays below freq_base so the shifted value fits in 33 bits.
   always_comb begin
      rem_sh   = {rem, 1'b0};
      rem_diff = rem_sh - DIVISOR;
      q_bit    = rem_sh >= DIVISOR;
      rem_nxt  = q_bit ? rem_diff[31:0] : rem_sh[31:0];
   end

   assign set_ready = (state == IDLE);
   assign busy      = ~set_ready;

   always_ff @(posedge clk_base or posedge aclr) begin
      if (aclr) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      apply_now = 1'b0;
      case (state)
         IDLE: begin
            if (set_valid) begin
               accept    = 1'b1;
               state_nxt = DIV;
            end
         end
         DIV: begin
            if (cnt == 5'd31) state_nxt = APPLY;
         end
         APPLY: begin
            // Swap on a wrap so the old period completes; a stopped or stopping output swaps at once.
            if (carry || (inc_cur == '0) || (inc_pend == '0)) begin
               apply_now = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_base or posedge aclr) begin
      if (aclr) begin
         rem      <= '0;
         quot     <= '0;
         cnt      <= '0;
         inc_pend <= '0;
         set_err  <= 1'b0;
      end else begin
         set_err <= 1'b0;
         if (accept) begin
            rem     <= f_req;
            quot    <= '0;
            cnt     <= '0;
            set_err <= clamped;
         end
         if (state == DIV) begin
            rem  <= rem_nxt;
            quot <= {quot[30:0], q_bit};
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) inc_pend <= {quot[30:0], q_bit};
         end
      end
   end

   always_ff @(posedge clk_base or posedge aclr) begin
      if (aclr) begin
         acc     <= '0;
         inc_cur <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         acc     <= sum[ACC_W-1:0];
         clk_out <= sum[ACC_W-1];
         tick    <= carry;
         if (apply_now) inc_cur <= inc_pend;
      end
   end

endmodule

// File: tb/tb_freq_gen_module.sv
// tb/tb_freq_gen_module.sv - scoreboard bench for freq_gen_module at freq_base=1000
// Accepted requests queue their expected increment; a monitor checks each one as busy falls.
module tb_freq_gen_module;

   logic        clk_base = 1'b0;
   logic        aclr;
   logic [31:0] freq_set;
   logic        set_valid;
   logic        set_ready;
   logic        set_err;
   logic        clk_out;
   logic        tick;
   logic [31:0] inc_cur;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] inc;
      logic        err;
      int          lo;
      int          hi;
   } exp_t;
   exp_t sb[$];

   freq_gen_module #(.freq_base(32'd1000), .ACC_W(32)) dut (
      .clk_base (clk_base),
      .aclr     (aclr),
      .freq_set (freq_set),
      .set_valid(set_valid),
      .set_ready(set_ready),
      .set_err  (set_err),
      .clk_out  (clk_out),
      .tick     (tick),
      .inc_cur  (inc_cur),
      .busy     (busy)
   );

   always #5 clk_base = ~clk_base;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: busy falling marks the completion of an accepted request.
   logic prev_busy = 1'b0;
   logic err_seen  = 1'b0;
   int   busy_cnt  = 0;
   always @(negedge clk_base) begin
      exp_t e;
      if (aclr) begin
         busy_cnt = 0;
         err_seen = 1'b0;
      end else begin
         if (set_err) err_seen = 1'b1;
         if (busy) busy_cnt++;
         if (prev_busy && !busy) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_unexpected: completion with inc_cur %0h but nothing expected", inc_cur);
            end else begin
               e = sb.pop_front();
               chk("sb_inc_cur", inc_cur, e.inc);
               chk("sb_set_err", {31'd0, err_seen}, {31'd0, e.err});
               vectors++;
               if (busy_cnt < e.lo || busy_cnt > e.hi) begin
                  miscompares++;
                  $display("FAIL sb_busy_cycles: got %0d expected %0d..%0d", busy_cnt, e.lo, e.hi);
               end
            end
            busy_cnt = 0;
            err_seen = 1'b0;
         end
      end
      prev_busy = busy;
   end

   task automatic do_set(input logic [31:0] f, input logic [31:0] exp_inc, input logic exp_err,
                         input int lo, input int hi);
      exp_t e;
      int   n = 0;
      @(negedge clk_base);
      while (!set_ready && n < 3000) begin
         @(negedge clk_base);
         n++;
      end
      if (!set_ready) chk("set_ready_timeout", {31'd0, set_ready}, 32'd1);
      e.inc = exp_inc; e.err = exp_err; e.lo = lo; e.hi = hi;
      sb.push_back(e);
      freq_set  = f;
      set_valid = 1'b1;
      @(posedge clk_base);
      #1 set_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk_base);
      while (busy && n < 3000) begin
         @(negedge clk_base);
         n++;
      end
      if (busy) chk("busy_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_reset(string tag);
      chk({tag, "_set_ready"}, {31'd0, set_ready}, 32'd1);
      chk({tag, "_busy"},      {31'd0, busy},      32'd0);
      chk({tag, "_set_err"},   {31'd0, set_err},   32'd0);
      chk({tag, "_clk_out"},   {31'd0, clk_out},   32'd0);
      chk({tag, "_tick"},      {31'd0, tick},      32'd0);
      chk({tag, "_inc_cur"},   inc_cur,            32'd0);
   endtask

   initial begin
      logic co[16];
      logic tk[16];
      int   ok, cnt, last, sw_i, min_iv, post, bad;
      logic switched, tick_sw, hold;

      aclr = 1'b1; set_valid = 1'b0; freq_set = '0;
      repeat (3) @(posedge clk_base);
      @(negedge clk_base);
      check_reset("rst_init");
      @(posedge clk_base);
      #1 aclr = 1'b0;

      // Reset in the middle of a divide discards the request.
      @(posedge clk_base);
      #1 freq_set = 32'd300; set_valid = 1'b1;
      @(posedge clk_base);
      #1 set_valid = 1'b0;
      repeat (10) @(posedge clk_base);
      #1 aclr = 1'b1;
      sb.delete();
      @(negedge clk_base);
      check_reset("rst_mid_div");
      @(posedge clk_base);
      #1 aclr = 1'b0;
      @(negedge clk_base);
      chk("rst_ready_next", {31'd0, set_ready}, 32'd1);
      repeat (50) @(negedge clk_base);
      chk("rst_discarded_inc", inc_cur, 32'd0);

      // 250 Hz: period 4 clk, 2 high / 2 low.
      do_set(32'd250, 32'h4000_0000, 1'b0, 33, 34);
      wait_idle();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_base);
         co[i] = clk_out; tk[i] = tick;
      end
      ok = 1; cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (tk[i]) cnt++;
         if (i >= 2 && co[i] == co[i-2]) ok = 0;
         if (i >= 4 && tk[i] != tk[i-4]) ok = 0;
      end
      chk("f250_shape", ok, 1);
      chk("f250_tick_count", cnt, 4);

      // 500 Hz: toggle every clk.
      do_set(32'd500, 32'h8000_0000, 1'b0, 33, 36);
      wait_idle();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_base);
         co[i] = clk_out; tk[i] = tick;
      end
      ok = 1; cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (tk[i]) cnt++;
         if (i >= 1 && co[i] == co[i-1]) ok = 0;
      end
      chk("f500_toggle", ok, 1);
      chk("f500_tick_count", cnt, 4);

      // 600 Hz clamps to 500 Hz with an error pulse.
      do_set(32'd600, 32'h8000_0000, 1'b1, 33, 34);
      wait_idle();

      // 1 Hz: 9 or 10 ticks in 10000 clk.
      do_set(32'd1, 32'd4294967, 1'b0, 33, 34);
      wait_idle();
      cnt = 0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk_base);
         if (tick) cnt++;
      end
      chk("f1_ticks_9_or_10", (cnt == 9 || cnt == 10), 1);

      // 250 -> 125 switches on a tick, never shortening a period; busy-time request is ignored.
      do_set(32'd250, 32'h4000_0000, 1'b0, 33, 1100);
      wait_idle();
      do_set(32'd125, 32'h2000_0000, 1'b0, 33, 36);
      @(posedge clk_base);
      #1 freq_set = 32'd7; set_valid = 1'b1;
      @(posedge clk_base);
      #1 set_valid = 1'b0;
      last = -1; sw_i = -1; min_iv = 1000; post = 0; bad = 0;
      switched = 1'b0; tick_sw = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_base);
         if (!switched && inc_cur == 32'h2000_0000) begin
            switched = 1'b1; tick_sw = tick; sw_i = i;
         end
         if (tick) begin
            if (last >= 0) begin
               if (i - last < min_iv) min_iv = i - last;
               if (switched && last >= sw_i) begin
                  post++;
                  if (i - last != 8) bad++;
               end
            end
            last = i;
         end
      end
      chk("f125_switched", {31'd0, switched}, 32'd1);
      chk("f125_switch_on_tick", {31'd0, tick_sw}, 32'd1);
      chk("f125_min_period_ge4", (min_iv >= 4), 1);
      chk("f125_post_ticks_ge3", (post >= 3), 1);
      chk("f125_period8_bad", bad, 0);

      // 0 Hz freezes the output.
      do_set(32'd0, 32'd0, 1'b0, 33, 34);
      wait_idle();
      hold = clk_out; bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_base);
         if (clk_out != hold || tick) bad++;
      end
      chk("f0_frozen", bad, 0);

      repeat (5) @(negedge clk_base);
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
